serial_parity_checker: RTL and testbench
========================================

SERIAL_PARITY_CHECKER -- requirements
Module: serial_parity_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning data bits per frame (legal range 2..32).
REQ-002 SHALL have parameter ODD_MODE, default 0, meaning parity sense (0 = even parity, 1 = odd parity).
REQ-003 SHALL have port clock, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning reset; it is synchronous and active-high.
REQ-005 SHALL have port start, input, 1, meaning begin a frame; sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1, meaning discard the current frame.
REQ-007 SHALL have port bit_valid, input, 1, meaning bit_in is valid this cycle.
REQ-008 SHALL have port bit_in, input, 1, meaning serial data/parity bit, sent MSB first.
REQ-009 SHALL have port busy, output, 1, meaning the FSM is not in IDLE.
REQ-010 SHALL have port done, output, 1, meaning a one-cycle pulse when a frame completes.
REQ-011 SHALL have port parity_ok, output, 1, meaning the parity result of the last completed frame.
REQ-012 SHALL have port data_out, output, DATA_W, meaning the data bits of the last completed frame.
REQ-013 SHALL have port err_count, output, 8, meaning a saturating count of frames that failed parity.

Function
REQ-014 SHALL implement FSM states IDLE, DATA, PARITY and DONE, with all outputs registered.
REQ-015 SHALL move from IDLE to DATA on start=1, clearing the shift register, the bit counter and the parity accumulator.
REQ-016 SHALL, in DATA with bit_valid=1, shift bit_in into the LSB of the shift register, XOR it into the accumulator and increment the bit counter.
REQ-017 SHALL hold all state in DATA and PARITY when bit_valid=0 (stall), with no limit on stall length.
REQ-018 SHALL move from DATA to PARITY on the valid bit taken when the counter equals DATA_W-1.
REQ-019 SHALL, in PARITY with bit_valid=1, compute ok = ((acc XOR bit_in) == ODD_MODE) and then move to DONE.
REQ-020 SHALL, in DONE, assert done for exactly one cycle, update data_out and parity_ok, and increment err_count if ok=0; then return to IDLE.
REQ-021 SHALL saturate err_count at 255 and never wrap it.
REQ-022 SHALL hold data_out and parity_ok stable between done pulses.
REQ-023 SHALL ignore start outside IDLE; start and bit_valid in the same IDLE cycle SHALL NOT consume the bit.
REQ-024 SHALL, on abort=1 in DATA or PARITY, return to IDLE next cycle with no done pulse and no output or err_count change; abort SHALL win over a simultaneous bit_valid.
REQ-025 SHALL ignore abort in IDLE and DONE.
REQ-026 SHALL have a minimum frame latency of DATA_W+3 cycles from start to done (start cycle + DATA_W data bits + parity bit + DONE).

Reset
REQ-027 SHALL, on reset=1 at a clock edge, force state=IDLE, busy=0, done=0, parity_ok=0, data_out=0, err_count=0, counter=0 and accumulator=0.
REQ-028 SHALL let reset override start, abort and bit_valid, including mid-frame.

Structure
REQ-029 SHALL put the state enum and the ERR_MAX=255 constant in shared package parity_pkg.
REQ-030 SHALL use no sub-module; it is a single FSM plus datapath.

Verification
REQ-031 SHALL test DATA_W=8, ODD_MODE=0: start, bits of 0xA5, parity 0 -> done pulse, data_out=0xA5, parity_ok=1, err_count=0.
REQ-032 SHALL test the same frame with parity 1 -> parity_ok=0, err_count=1.
REQ-033 SHALL test 0xA5 with parity 0 and 3-cycle bit_valid=0 gaps between bits -> same result as REQ-031, done delayed by the gap cycles.
REQ-034 SHALL test abort after 4 bits -> no done pulse, outputs unchanged, busy=0 next cycle; a new frame SHALL then run correctly.
REQ-035 SHALL test 260 consecutive bad-parity frames -> err_count=255, with no wrap.
REQ-036 SHALL test ODD_MODE=1, DATA_W=4: data 0x1 with parity 0 -> parity_ok=1; reset asserted mid-frame -> all outputs 0 and state IDLE.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared types and constants for the serial parity checker.
// Holds the frame FSM state encoding and the error counter ceiling.
// No logic lives here; it is imported by the checker.
package parity_pkg;

    // Frame FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Saturation ceiling for the failed-parity frame counter
    localparam logic [7:0] ERR_MAX = 8'd255;

endpackage

// File: rtl/serial_parity_checker.sv
// Receives a serial frame (DATA_W data bits MSB first, then one parity bit) and checks parity.
// Latency: done pulses DATA_W+3 cycles after the start cycle when bit_valid is held high.
// Backpressure: bit_valid=0 stalls DATA/PARITY indefinitely; abort drops the frame silently.
module serial_parity_checker
    import parity_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter bit ODD_MODE = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic              busy,
    output logic              done,
    output logic              parity_ok,
    output logic [DATA_W-1:0] data_out,
    output logic [7:0]        err_count
);

    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_t            state;
    logic [DATA_W-1:0] shift_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              acc_q;
    logic              frame_ok;

    // Parity verdict for the bit currently on bit_in, valid while in PARITY
    assign frame_ok = ((acc_q ^ bit_in) == ODD_MODE);

    // Frame FSM with shift register, bit counter, parity accumulator and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            acc_q     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            parity_ok <= 1'b0;
            data_out  <= '0;
            err_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A bit_valid arriving with start belongs to no frame yet
                    if (start) begin
                        state   <= DATA;
                        busy    <= 1'b1;
                        shift_q <= '0;
                        cnt_q   <= '0;
                        acc_q   <= 1'b0;
                    end
                end
                DATA: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (bit_valid) begin
                        shift_q <= {shift_q[DATA_W-2:0], bit_in};
                        acc_q   <= acc_q ^ bit_in;
                        cnt_q   <= cnt_q + 1'b1;
                        if (cnt_q == LAST_BIT) begin
                            state <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (bit_valid) begin
                        // Results are published on entry to DONE so done is high during DONE
                        state     <= DONE;
                        done      <= 1'b1;
                        data_out  <= shift_q;
                        parity_ok <= frame_ok;
                        if (!frame_ok && (err_count != ERR_MAX)) begin
                            err_count <= err_count + 8'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench for serial_parity_checker: an even-parity 8-bit instance and an odd-parity 4-bit instance.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
// Each scenario task carries its own expected values.
module tb_serial_parity_checker;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // 8-bit even-parity instance
    logic       reset = 1'b1, start = 1'b0, abort = 1'b0, bit_valid = 1'b0, bit_in = 1'b0;
    logic       busy, done, parity_ok;
    logic [7:0] data_out, err_count;

    // 4-bit odd-parity instance
    logic       r4_reset = 1'b1, r4_start = 1'b0, r4_abort = 1'b0, r4_bit_valid = 1'b0, r4_bit_in = 1'b0;
    logic       r4_busy, r4_done, r4_parity_ok;
    logic [3:0] r4_data_out;
    logic [7:0] r4_err_count;

    int checks = 0;
    int passed = 0;

    serial_parity_checker #(.DATA_W(8), .ODD_MODE(1'b0)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .bit_valid(bit_valid), .bit_in(bit_in), .busy(busy), .done(done),
        .parity_ok(parity_ok), .data_out(data_out), .err_count(err_count)
    );

    serial_parity_checker #(.DATA_W(4), .ODD_MODE(1'b1)) dut4 (
        .clock(clock), .reset(r4_reset), .start(r4_start), .abort(r4_abort),
        .bit_valid(r4_bit_valid), .bit_in(r4_bit_in), .busy(r4_busy), .done(r4_done),
        .parity_ok(r4_parity_ok), .data_out(r4_data_out), .err_count(r4_err_count)
    );

    // Drives one 8-bit frame; a stray bit_valid rides along with start and must be ignored.
    // lat counts rising edges from the start edge until done is seen (bounded).
    task automatic run_frame(input logic [7:0] d, input logic p, input int gap, output int lat);
        logic b;
        @(negedge clock);
        start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1; lat = 0;
        @(negedge clock);
        start = 1'b0; bit_valid = 1'b0; lat++;
        for (int i = 0; i < 9; i++) begin
            b = (i < 8) ? d[7-i] : p;
            if (i > 0) begin
                repeat (gap) begin
                    @(negedge clock);
                    lat++;
                end
            end
            bit_valid = 1'b1; bit_in = b;
            @(negedge clock);
            lat++;
            bit_valid = 1'b0;
        end
        while (done !== 1'b1 && lat < 200) begin
            @(negedge clock);
            lat++;
        end
    endtask

    // Drives one 4-bit frame on the odd-parity instance with no gaps
    task automatic run_frame4(input logic [3:0] d, input logic p, output int lat);
        @(negedge clock);
        r4_start = 1'b1; lat = 0;
        @(negedge clock);
        r4_start = 1'b0; lat++;
        for (int i = 0; i < 5; i++) begin
            r4_bit_valid = 1'b1; r4_bit_in = (i < 4) ? d[3-i] : p;
            @(negedge clock);
            lat++;
            r4_bit_valid = 1'b0;
        end
        while (r4_done !== 1'b1 && lat < 200) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; r4_reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0; r4_reset = 1'b0;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
        checks++; if (parity_ok !== 1'b0) $display("FAIL reset_parity_ok got %b want 0", parity_ok); else passed++;
        checks++; if (data_out !== 8'h00) $display("FAIL reset_data_out got %h want 00", data_out); else passed++;
        checks++; if (err_count !== 8'd0) $display("FAIL reset_err_count got %0d want 0", err_count); else passed++;
    endtask

    task automatic test_good_frame;
        int lat;
        run_frame(8'hA5, 1'b0, 0, lat);
        checks++; if (done !== 1'b1) $display("FAIL good_done got %b want 1", done); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL good_busy_in_done got %b want 1", busy); else passed++;
        checks++; if (data_out !== 8'hA5) $display("FAIL good_data got %h want a5", data_out); else passed++;
        checks++; if (parity_ok !== 1'b1) $display("FAIL good_parity_ok got %b want 1", parity_ok); else passed++;
        checks++; if (err_count !== 8'd0) $display("FAIL good_err got %0d want 0", err_count); else passed++;
        // start edge + 8 data edges + parity edge, so done is visible in the 11th cycle
        checks++; if (lat !== 10) $display("FAIL good_latency got %0d want 10", lat); else passed++;
        @(negedge clock);
        checks++; if (done !== 1'b0) $display("FAIL good_done_one_cycle got %b want 0", done); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL good_busy_after got %b want 0", busy); else passed++;
    endtask

    task automatic test_bad_parity;
        int lat;
        run_frame(8'hA5, 1'b1, 0, lat);
        checks++; if (done !== 1'b1) $display("FAIL bad_done got %b want 1", done); else passed++;
        checks++; if (parity_ok !== 1'b0) $display("FAIL bad_parity_ok got %b want 0", parity_ok); else passed++;
        checks++; if (err_count !== 8'd1) $display("FAIL bad_err got %0d want 1", err_count); else passed++;
        // Outputs must hold while idle bits fly past
        repeat (5) begin
            @(negedge clock);
            bit_valid = 1'b1; bit_in = 1'b1;
        end
        @(negedge clock);
        bit_valid = 1'b0;
        checks++; if (data_out !== 8'hA5) $display("FAIL bad_hold_data got %h want a5", data_out); else passed++;
        checks++; if (parity_ok !== 1'b0) $display("FAIL bad_hold_ok got %b want 0", parity_ok); else passed++;
        checks++; if (err_count !== 8'd1) $display("FAIL bad_hold_err got %0d want 1", err_count); else passed++;
    endtask

    task automatic test_stall;
        int lat;
        run_frame(8'hA5, 1'b0, 3, lat);
        checks++; if (done !== 1'b1) $display("FAIL stall_done got %b want 1", done); else passed++;
        checks++; if (data_out !== 8'hA5) $display("FAIL stall_data got %h want a5", data_out); else passed++;
        checks++; if (parity_ok !== 1'b1) $display("FAIL stall_parity_ok got %b want 1", parity_ok); else passed++;
        checks++; if (err_count !== 8'd1) $display("FAIL stall_err got %0d want 1", err_count); else passed++;
        // 10 edges plus 3 idle cycles before each of the 7 later data bits and the parity bit
        checks++; if (lat !== 34) $display("FAIL stall_latency got %0d want 34", lat); else passed++;
    endtask

    task automatic test_abort;
        int lat;
        int done_seen;
        logic [3:0] pre;
        pre = 4'b1010;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1; bit_in = pre[3-i];
            @(negedge clock);
        end
        // Abort collides with a valid bit and must win
        abort = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        @(negedge clock);
        abort = 1'b0; bit_valid = 1'b0;
        checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passed++;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) done_seen++;
            @(negedge clock);
        end
        checks++; if (done_seen !== 0) $display("FAIL abort_no_done got %0d pulses want 0", done_seen); else passed++;
        checks++; if (data_out !== 8'hA5) $display("FAIL abort_data got %h want a5", data_out); else passed++;
        checks++; if (err_count !== 8'd1) $display("FAIL abort_err got %0d want 1", err_count); else passed++;
        run_frame(8'h3C, 1'b0, 0, lat);
        checks++; if (data_out !== 8'h3C) $display("FAIL after_abort_data got %h want 3c", data_out); else passed++;
        checks++; if (parity_ok !== 1'b1) $display("FAIL after_abort_ok got %b want 1", parity_ok); else passed++;
        checks++; if (lat !== 10) $display("FAIL after_abort_latency got %0d want 10", lat); else passed++;
    endtask

    task automatic test_saturation;
        int lat;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        // 0x01 carries one set bit, so parity bit 0 fails in even mode
        for (int i = 0; i < 260; i++) begin
            run_frame(8'h01, 1'b0, 0, lat);
            if (i == 253) begin
                checks++; if (err_count !== 8'd254) $display("FAIL sat_254 got %0d want 254", err_count); else passed++;
            end
            if (i == 254) begin
                checks++; if (err_count !== 8'd255) $display("FAIL sat_255 got %0d want 255", err_count); else passed++;
            end
        end
        checks++; if (err_count !== 8'd255) $display("FAIL sat_nowrap got %0d want 255", err_count); else passed++;
        checks++; if (parity_ok !== 1'b0) $display("FAIL sat_parity_ok got %b want 0", parity_ok); else passed++;
    endtask

    task automatic test_odd_mode;
        int lat;
        run_frame4(4'h1, 1'b1, lat);
        checks++; if (r4_parity_ok !== 1'b0) $display("FAIL odd_bad_ok got %b want 0", r4_parity_ok); else passed++;
        checks++; if (r4_err_count !== 8'd1) $display("FAIL odd_bad_err got %0d want 1", r4_err_count); else passed++;
        run_frame4(4'h1, 1'b0, lat);
        checks++; if (r4_done !== 1'b1) $display("FAIL odd_good_done got %b want 1", r4_done); else passed++;
        checks++; if (r4_parity_ok !== 1'b1) $display("FAIL odd_good_ok got %b want 1", r4_parity_ok); else passed++;
        checks++; if (r4_data_out !== 4'h1) $display("FAIL odd_good_data got %h want 1", r4_data_out); else passed++;
        checks++; if (lat !== 6) $display("FAIL odd_latency got %0d want 6", lat); else passed++;
    endtask

    task automatic test_midframe_reset;
        int lat;
        @(negedge clock);
        r4_start = 1'b1;
        @(negedge clock);
        r4_start = 1'b0;
        r4_bit_valid = 1'b1; r4_bit_in = 1'b1;
        @(negedge clock);
        @(negedge clock);
        r4_reset = 1'b1; r4_abort = 1'b1;
        @(negedge clock);
        r4_reset = 1'b0; r4_abort = 1'b0; r4_bit_valid = 1'b0;
        checks++; if (r4_busy !== 1'b0) $display("FAIL rst_busy got %b want 0", r4_busy); else passed++;
        checks++; if (r4_done !== 1'b0) $display("FAIL rst_done got %b want 0", r4_done); else passed++;
        checks++; if (r4_parity_ok !== 1'b0) $display("FAIL rst_ok got %b want 0", r4_parity_ok); else passed++;
        checks++; if (r4_data_out !== 4'h0) $display("FAIL rst_data got %h want 0", r4_data_out); else passed++;
        checks++; if (r4_err_count !== 8'd0) $display("FAIL rst_err got %0d want 0", r4_err_count); else passed++;
        // A fresh frame must start from a clean IDLE: 0x6 has two ones, parity 1 makes it odd
        run_frame4(4'h6, 1'b1, lat);
        checks++; if (r4_data_out !== 4'h6) $display("FAIL rst_next_data got %h want 6", r4_data_out); else passed++;
        checks++; if (r4_parity_ok !== 1'b1) $display("FAIL rst_next_ok got %b want 1", r4_parity_ok); else passed++;
        checks++; if (lat !== 6) $display("FAIL rst_next_latency got %0d want 6", lat); else passed++;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_parity();
        test_stall();
        test_abort();
        test_odd_mode();
        test_midframe_reset();
        test_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
